// File: rtl/aidan_mcnay_div_arbiter_pkg.sv
// Shared types and constants for the round-robin divider arbiter.
// Stats option is controlled by AIDAN_MCNAY_DIV_ARB_STATS_EN in the top.
package aidan_mcnay_div_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int STAT_W = 8;

    // Index width for a pointer over n requesters; never narrower than 1 bit.
    function automatic int clog2_idx(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/aidan_mcnay_rr_pick.sv
// Combinational round-robin pick: first asserted request after ptr, wrapping
// at nreq-1 explicitly so non-power-of-two counts never select a phantom index.
module aidan_mcnay_rr_pick #(
    parameter int nreq = 4,
    parameter int pw   = 2
) (
    input  logic [nreq-1:0] req,
    input  logic [pw-1:0]   ptr,
    output logic [pw-1:0]   grant,
    output logic            any
);

    logic [pw-1:0] idx;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = ptr;
        for (int k = 0; k < nreq; k++) begin
            idx = (idx == pw'(nreq - 1)) ? '0 : idx + 1'b1;
            if (!any && req[idx]) begin
                grant = idx;
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aidan_mcnay_div_arbiter.sv
// Shares one val/rdy divider among nreq requesters, round-robin, one in flight.
// Define AIDAN_MCNAY_DIV_ARB_STATS_EN to add per-requester completion counters.
module aidan_mcnay_div_arbiter
    import aidan_mcnay_div_arbiter_pkg::*;
#(
    parameter int nbits = 16,
    parameter int nreq  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [nreq-1:0]       req_istream_val,
    output logic [nreq-1:0]       req_istream_rdy,
    input  logic [nreq*nbits-1:0] req_dividend,
    input  logic [nreq*nbits-1:0] req_divisor,
    output logic [nreq-1:0]       req_ostream_val,
    input  logic [nreq-1:0]       req_ostream_rdy,
    output logic [nbits-1:0]      resp_result,
    output logic                  div_istream_val,
    input  logic                  div_istream_rdy,
    output logic [nbits-1:0]      div_dividend,
    output logic [nbits-1:0]      div_divisor,
    input  logic                  div_ostream_val,
    output logic                  div_ostream_rdy,
    input  logic [nbits-1:0]      div_result,
    output logic                  busy
`ifdef AIDAN_MCNAY_DIV_ARB_STATS_EN
    ,
    output logic [nreq*STAT_W-1:0] stat_done_count
`endif
);

    localparam int PW = clog2_idx(nreq);

    state_t           state, state_next;
    logic [PW-1:0]    ptr, g, pick;
    logic             any;
    logic             done;
    logic [nbits-1:0] dividend_q, divisor_q;
    logic [nbits-1:0] dvd_arr [nreq];
    logic [nbits-1:0] dvs_arr [nreq];

    for (genvar i = 0; i < nreq; i++) begin : g_unpack
        assign dvd_arr[i] = req_dividend[i*nbits +: nbits];
        assign dvs_arr[i] = req_divisor[i*nbits +: nbits];
    end

    aidan_mcnay_rr_pick #(
        .nreq (nreq),
        .pw   (PW)
    ) u_pick (
        .req   (req_istream_val),
        .ptr   (ptr),
        .grant (pick),
        .any   (any)
    );

    assign done = (state == WAIT) && div_ostream_val && req_ostream_rdy[g];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= PW'(nreq - 1);
            g          <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && any) begin
                g          <= pick;
                dividend_q <= dvd_arr[pick];
                divisor_q  <= dvs_arr[pick];
            end
            // Completed requester drops to lowest priority for the next pick.
            if (done)
                ptr <= g;
        end
    end

    always_comb begin
        state_next      = state;
        req_istream_rdy = '0;
        req_ostream_val = '0;
        div_istream_val = 1'b0;
        div_ostream_rdy = 1'b0;
        case (state)
            IDLE: begin
                if (any) begin
                    req_istream_rdy[pick] = 1'b1;
                    state_next            = ISSUE;
                end
            end
            ISSUE: begin
                div_istream_val = 1'b1;
                if (div_istream_rdy)
                    state_next = WAIT;
            end
            WAIT: begin
                req_ostream_val[g] = div_ostream_val;
                div_ostream_rdy    = req_ostream_rdy[g];
                if (done)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;
    assign resp_result  = div_result;
    assign busy         = (state != IDLE);

`ifdef AIDAN_MCNAY_DIV_ARB_STATS_EN
    for (genvar i = 0; i < nreq; i++) begin : g_stat
        logic [STAT_W-1:0] cnt;
        always_ff @(posedge clk) begin
            if (reset)
                cnt <= '0;
            else if (done && g == PW'(i) && cnt != '1)
                cnt <= cnt + 1'b1;
        end
        assign stat_done_count[i*STAT_W +: STAT_W] = cnt;
    end
`endif

endmodule
